// File: rtl/ai_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ai_pkg
//  Description : Shared AI-subsystem definitions. Holds the fetch-FSM state
//                encoding and the default camera image geometry that the
//                register file, the AI core and the picture fetch controller
//                all use.
//  Revision    : 1.0  initial release
// ============================================================================
package ai_pkg;

    // Frame-fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BEAT = 2'd2,
        ST_FIN  = 2'd3
    } fetch_state_t;

    // Default image geometry and datapath widths
    localparam int DEF_IMG_W     = 32;
    localparam int DEF_IMG_H     = 32;
    localparam int DEF_BURST_LEN = 8;
    localparam int DEF_DW        = 16;
    localparam int DEF_XW        = 8;

endpackage
`default_nettype wire

// File: rtl/ai_xy_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ai_xy_counter
//  Description : Pixel coordinate tracker for the picture fetch controller.
//                x counts columns and wraps at the end of each line, which
//                advances y. A separate beat counter tracks the position
//                inside the current burst.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   clock
//    rst_n      in   asynchronous active-low reset
//    clr        in   zero all counters (frame start)
//    inc        in   one pixel transferred
//    x          out  current column
//    y          out  current line
//    burst_end  out  current beat is the last one of its burst
//    frame_end  out  current pixel is the last one of the frame
// ============================================================================
module ai_xy_counter
    import ai_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int XW        = DEF_XW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [XW-1:0] x,
    output logic [XW-1:0] y,
    output logic          burst_end,
    output logic          frame_end
);

    localparam logic [XW-1:0] c_X_LAST    = XW'(IMG_W - 1);
    localparam logic [XW-1:0] c_Y_LAST    = XW'(IMG_H - 1);
    localparam logic [XW-1:0] c_BEAT_LAST = XW'(BURST_LEN - 1);

    logic [XW-1:0] r_x;
    logic [XW-1:0] r_y;
    logic [XW-1:0] r_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_beat <= '0;
        end else if (clr) begin
            r_x    <= '0;
            r_y    <= '0;
            r_beat <= '0;
        end else if (inc) begin
            if (r_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
            if (r_beat == c_BEAT_LAST) begin
                r_beat <= '0;
            end else begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    assign x         = r_x;
    assign y         = r_y;
    assign burst_end = (r_beat == c_BEAT_LAST);
    assign frame_end = (r_x == c_X_LAST) && (r_y == c_Y_LAST);

endmodule
`default_nettype wire

// File: rtl/ai_pic_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ai_pic_fetch_ctrl
//  Description : Moves one camera frame from the frame-buffer read port into
//                the AI core input-feature-map stream. Issues one burst read
//                request at a time, forwards the returned pixels tagged with
//                their (x, y) position and checks the buffer's frame-boundary
//                flags against the expected positions.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, rst_n                   AI clock, async active-low reset
//    start, abort                 single-cycle control pulses from regfile
//    busy, done, err              status to regfile / interrupt logic
//    req_valid/ready/first/last   burst read request channel
//    rsp_valid/ready/first/last,
//    rsp_data                     pixel return channel from the buffer
//    out_valid/ready, out_data,
//    out_x, out_y                 pixel stream to the AI core
// ============================================================================
module ai_pic_fetch_ctrl
    import ai_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int DW        = DEF_DW,
    parameter int XW        = DEF_XW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          req_valid,
    input  logic          req_ready,
    output logic          req_first,
    output logic          req_last,
    input  logic          rsp_valid,
    input  logic          rsp_first,
    input  logic          rsp_last,
    input  logic [DW-1:0] rsp_data,
    output logic          rsp_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [XW-1:0] out_x,
    output logic [XW-1:0] out_y,
    input  logic          out_ready
);

    // Geometry sanity: bursts must tile a line exactly, and the coordinate
    // counters must be able to hold the largest coordinate.
    if ((IMG_W % BURST_LEN) != 0) begin : g_bad_burst_len
        $error("ai_pic_fetch_ctrl: BURST_LEN must divide IMG_W");
    end
    if (((1 << XW) < IMG_W) || ((1 << XW) < IMG_H)) begin : g_bad_xw
        $error("ai_pic_fetch_ctrl: XW too narrow for image geometry");
    end

    // Column at which the final burst of a line starts
    localparam logic [XW-1:0] c_X_LAST_REQ = XW'(IMG_W - BURST_LEN);
    localparam logic [XW-1:0] c_Y_LAST     = XW'(IMG_H - 1);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic          r_err;

    logic [XW-1:0] w_x;
    logic [XW-1:0] w_y;
    logic          w_burst_end;
    logic          w_frame_end;
    logic          w_start_ok;
    logic          w_xfer;
    logic          w_at_origin;
    logic          w_flag_bad;

    // abort beats start in the same IDLE cycle
    assign w_start_ok  = (r_state == ST_IDLE) && start && !abort;
    assign w_xfer      = (r_state == ST_BEAT) && rsp_valid && out_ready;
    assign w_at_origin = (w_x == '0) && (w_y == '0);
    // Last-pixel expectation coincides with the counter's frame_end
    assign w_flag_bad  = (rsp_first != w_at_origin) || (rsp_last != w_frame_end);

    ai_xy_counter #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .BURST_LEN (BURST_LEN),
        .XW        (XW)
    ) u_xy_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_start_ok),
        .inc       (w_xfer),
        .x         (w_x),
        .y         (w_y),
        .burst_end (w_burst_end),
        .frame_end (w_frame_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        req_valid   = 1'b0;
        req_first   = 1'b0;
        req_last    = 1'b0;
        rsp_ready   = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                busy      = 1'b1;
                req_valid = 1'b1;
                req_first = w_at_origin;
                req_last  = (w_x == c_X_LAST_REQ) && (w_y == c_Y_LAST);
                // Counters are frozen here, so the request and flags hold
                // steady across any stall.
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (req_ready) begin
                    w_state_nxt = ST_BEAT;
                end
            end
            ST_BEAT: begin
                busy      = 1'b1;
                rsp_ready = out_ready;
                out_valid = rsp_valid;
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_xfer && w_burst_end) begin
                    w_state_nxt = w_frame_end ? ST_FIN : ST_REQ;
                end
            end
            ST_FIN: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sticky boundary error; the fetch keeps running after a mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if (w_xfer && w_flag_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err      = r_err;
    assign out_data = rsp_data;
    assign out_x    = w_x;
    assign out_y    = w_y;

endmodule
`default_nettype wire

// File: tb/tb_ai_pic_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ai_pic_fetch_ctrl
//  Description : Directed self-checking bench for ai_pic_fetch_ctrl with a
//                4x4 image and 4-pixel bursts. Inputs change on the falling
//                edge; outputs are sampled 1 ns later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ai_pic_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic        req_valid;
    logic        req_ready;
    logic        req_first;
    logic        req_last;
    logic        rsp_valid;
    logic        rsp_first;
    logic        rsp_last;
    logic [15:0] rsp_data;
    logic        rsp_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_x;
    logic [7:0]  out_y;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    ai_pic_fetch_ctrl #(
        .IMG_W     (4),
        .IMG_H     (4),
        .BURST_LEN (4),
        .DW        (16),
        .XW        (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_first (req_first),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_first (rsp_first),
        .rsp_last  (rsp_last),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer pixel idx (0..15) of the frame; bad_* invert the boundary flag.
    task automatic drive_beat(input int idx, input logic bad_first, input logic bad_last);
        rsp_valid = 1'b1;
        rsp_first = logic'(idx == 0) ^ bad_first;
        rsp_last  = logic'(idx == 15) ^ bad_last;
        rsp_data  = 16'(32'hA000 + idx);
    endtask

    function automatic logic [31:0] pix_exp(input int idx);
        return {8'(idx % 4), 8'(idx / 4), 16'(32'hA000 + idx)};
    endfunction

    task automatic test_reset();
        logic [7:0] st;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; req_ready = 1'b1;
        rsp_valid = 1'b1; rsp_first = 1'b0; rsp_last = 1'b0; rsp_data = 16'h1234; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        st = {busy, done, err, req_valid, req_first, req_last, rsp_ready, out_valid};
        n_cmp++; if (st !== 8'h00) begin n_bad++; $display("FAIL rst_outputs: got %b want %b", st, 8'h00); end
        n_cmp++; if ({out_x, out_y} !== 16'h0000) begin n_bad++; $display("FAIL rst_xy: got %h want %h", {out_x, out_y}, 16'h0000); end
        @(negedge clk); rst_n = 1'b1; rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if ({busy, req_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_stay_idle: got %b want %b", {busy, req_valid}, 2'b00); end
    endtask

    task automatic test_nominal();
        logic [3:0]  er;
        logic [31:0] ep;
        @(negedge clk); start = 1'b1; req_ready = 1'b1; out_ready = 1'b1; rsp_valid = 1'b0;
        #1;
        n_cmp++; if ({busy, req_valid} !== 2'b00) begin n_bad++; $display("FAIL nom_idle: got %b want %b", {busy, req_valid}, 2'b00); end
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) begin
                @(negedge clk); start = 1'b0; rsp_valid = 1'b0;
                #1;
                er = {1'b1, logic'(i == 0), logic'(i == 12), 1'b1};
                n_cmp++; if ({req_valid, req_first, req_last, busy} !== er) begin n_bad++; $display("FAIL nom_req[%0d]: got %b want %b", i / 4, {req_valid, req_first, req_last, busy}, er); end
            end
            @(negedge clk); drive_beat(i, 1'b0, 1'b0);
            #1;
            ep = pix_exp(i);
            n_cmp++; if ({out_x, out_y, out_data} !== ep) begin n_bad++; $display("FAIL nom_pix[%0d]: got %h want %h", i, {out_x, out_y, out_data}, ep); end
            n_cmp++; if ({out_valid, rsp_ready, req_valid} !== 3'b110) begin n_bad++; $display("FAIL nom_hs[%0d]: got %b want %b", i, {out_valid, rsp_ready, req_valid}, 3'b110); end
        end
        @(negedge clk); rsp_valid = 1'b0;
        #1;
        n_cmp++; if ({done, busy, err, req_valid} !== 4'b1000) begin n_bad++; $display("FAIL nom_done: got %b want %b", {done, busy, err, req_valid}, 4'b1000); end
        @(negedge clk);
        #1;
        n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL nom_done_pulse: got %b want %b", {done, busy}, 2'b00); end
    endtask

    task automatic test_backpressure();
        int          idx = 0;
        int          got;
        int          cyc;
        int          stall;
        int          n_done = 0;
        logic        ord = 1'b0;
        logic [2:0]  er;
        logic [33:0] eb;
        @(negedge clk); start = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            stall = (r == 0) ? 5 : ((r == 3) ? 2 : 0);
            for (int s = 0; s <= stall; s++) begin
                @(negedge clk); start = 1'b0; rsp_valid = 1'b0; req_ready = logic'(s == stall);
                #1;
                er = {1'b1, logic'(r == 0), logic'(r == 3)};
                n_cmp++; if ({req_valid, req_first, req_last} !== er) begin n_bad++; $display("FAIL bp_req[%0d.%0d]: got %b want %b", r, s, {req_valid, req_first, req_last}, er); end
            end
            got = 0;
            cyc = 0;
            while (got < 4 && cyc < 20) begin
                @(negedge clk); ord = ~ord; out_ready = ord; drive_beat(idx, 1'b0, 1'b0);
                #1;
                eb = {1'b1, ord, pix_exp(idx)};
                n_cmp++; if ({out_valid, rsp_ready, out_x, out_y, out_data} !== eb) begin n_bad++; $display("FAIL bp_beat[%0d]: got %h want %h", idx, {out_valid, rsp_ready, out_x, out_y, out_data}, eb); end
                if (done) n_done++;
                if (ord) begin
                    idx++;
                    got++;
                end
                cyc++;
            end
        end
        @(negedge clk); rsp_valid = 1'b0; out_ready = 1'b1; req_ready = 1'b1;
        #1;
        n_cmp++; if ({done, busy, err} !== 3'b100) begin n_bad++; $display("FAIL bp_done: got %b want %b", {done, busy, err}, 3'b100); end
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done) n_done++;
        end
        n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL bp_extra_done: got %0d want %0d", n_done, 0); end
    endtask

    task automatic test_flag_err();
        logic [31:0] ep;
        @(negedge clk); start = 1'b1; req_ready = 1'b1; out_ready = 1'b1; rsp_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) begin
                @(negedge clk); start = 1'b0; rsp_valid = 1'b0;
                #1;
                if (i == 8) begin
                    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ferr_set: got %b want %b", err, 1'b1); end
                end
            end
            @(negedge clk); drive_beat(i, 1'b0, logic'(i == 7));
            #1;
            if (i == 7) begin
                n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ferr_early: got %b want %b", err, 1'b0); end
            end
            if (i == 12) begin
                ep = pix_exp(i);
                n_cmp++; if ({out_x, out_y, out_data} !== ep) begin n_bad++; $display("FAIL ferr_continue: got %h want %h", {out_x, out_y, out_data}, ep); end
            end
        end
        @(negedge clk); rsp_valid = 1'b0;
        #1;
        n_cmp++; if ({done, err} !== 2'b11) begin n_bad++; $display("FAIL ferr_done: got %b want %b", {done, err}, 2'b11); end
        @(negedge clk); start = 1'b1;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ferr_hold_idle: got %b want %b", err, 1'b1); end
        @(negedge clk); start = 1'b0; req_ready = 1'b0;
        #1;
        n_cmp++; if ({err, req_valid, req_first} !== 3'b011) begin n_bad++; $display("FAIL ferr_clear: got %b want %b", {err, req_valid, req_first}, 3'b011); end
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0; req_ready = 1'b1;
        #1;
        n_cmp++; if ({busy, req_valid} !== 2'b00) begin n_bad++; $display("FAIL ferr_abort_req: got %b want %b", {busy, req_valid}, 2'b00); end
    endtask

    task automatic test_abort();
        logic [4:0] st;
        @(negedge clk); start = 1'b1; req_ready = 1'b1; out_ready = 1'b1; rsp_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i % 4 == 0) begin
                @(negedge clk); start = 1'b0; rsp_valid = 1'b0;
            end
            // i==5 is the second BEAT cycle of request 1
            @(negedge clk); drive_beat(i, 1'b0, 1'b0); abort = logic'(i == 5);
        end
        @(negedge clk); abort = 1'b0; drive_beat(6, 1'b0, 1'b0);
        #1;
        st = {busy, done, rsp_ready, out_valid, req_valid};
        n_cmp++; if (st !== 5'b00000) begin n_bad++; $display("FAIL abt_idle: got %b want %b", st, 5'b00000); end
        @(negedge clk); rsp_valid = 1'b0;
        #1;
        n_cmp++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL abt_no_done: got %b want %b", {busy, done, err}, 3'b000); end
        // restart, then abort in REQ while req_ready is high
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b1;
        #1;
        n_cmp++; if ({req_valid, req_first, busy, out_x, out_y} !== {3'b111, 16'h0000}) begin n_bad++; $display("FAIL abt_restart: got %h want %h", {req_valid, req_first, busy, out_x, out_y}, {3'b111, 16'h0000}); end
        @(negedge clk); abort = 1'b0; drive_beat(0, 1'b0, 1'b0);
        #1;
        n_cmp++; if ({busy, out_valid, rsp_ready, req_valid} !== 4'b0000) begin n_bad++; $display("FAIL abt_req_wins: got %b want %b", {busy, out_valid, rsp_ready, req_valid}, 4'b0000); end
        // start and abort together in IDLE
        @(negedge clk); start = 1'b1; abort = 1'b1; rsp_valid = 1'b0;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        #1;
        n_cmp++; if ({busy, req_valid} !== 2'b00) begin n_bad++; $display("FAIL abt_start_drop: got %b want %b", {busy, req_valid}, 2'b00); end
    endtask

    task automatic test_start_busy();
        int          n_done = 0;
        logic [31:0] ep;
        @(negedge clk); start = 1'b1; req_ready = 1'b1; out_ready = 1'b1; rsp_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) begin
                @(negedge clk); start = logic'(i == 8); rsp_valid = 1'b0;
                #1;
                if (done) n_done++;
                if (i == 8) begin
                    n_cmp++; if ({req_valid, req_first} !== 2'b10) begin n_bad++; $display("FAIL sb_req_first: got %b want %b", {req_valid, req_first}, 2'b10); end
                end
            end
            @(negedge clk); start = logic'(i == 6); drive_beat(i, 1'b0, 1'b0);
            #1;
            if (done) n_done++;
            ep = pix_exp(i);
            n_cmp++; if ({out_x, out_y, out_data} !== ep) begin n_bad++; $display("FAIL sb_pix[%0d]: got %h want %h", i, {out_x, out_y, out_data}, ep); end
        end
        @(negedge clk); start = 1'b0; rsp_valid = 1'b0;
        #1;
        if (done) n_done++;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done) n_done++;
        end
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL sb_done_count: got %0d want %0d", n_done, 1); end
        n_cmp++; if ({busy, err} !== 2'b00) begin n_bad++; $display("FAIL sb_end_state: got %b want %b", {busy, err}, 2'b00); end
    endtask

    task automatic test_async_reset();
        logic [7:0] st;
        @(negedge clk); start = 1'b1; req_ready = 1'b1; out_ready = 1'b1; rsp_valid = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk); drive_beat(0, 1'b1, 1'b0);
        @(negedge clk); drive_beat(1, 1'b0, 1'b0);
        #1;
        n_cmp++; if ({err, busy, out_valid, out_x} !== {3'b111, 8'd1}) begin n_bad++; $display("FAIL ar_pre: got %h want %h", {err, busy, out_valid, out_x}, {3'b111, 8'd1}); end
        #2 rst_n = 1'b0;
        #1;
        st = {busy, done, err, req_valid, req_first, req_last, rsp_ready, out_valid};
        n_cmp++; if (st !== 8'h00) begin n_bad++; $display("FAIL ar_outputs: got %b want %b", st, 8'h00); end
        n_cmp++; if ({out_x, out_y} !== 16'h0000) begin n_bad++; $display("FAIL ar_xy: got %h want %h", {out_x, out_y}, 16'h0000); end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_cmp++; if ({busy, req_valid, out_valid} !== 3'b000) begin n_bad++; $display("FAIL ar_stay_idle[%0d]: got %b want %b", k, {busy, req_valid, out_valid}, 3'b000); end
        end
        rsp_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_first = 1'b0; rsp_last = 1'b0; rsp_data = '0; out_ready = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_flag_err();
        test_abort();
        test_start_busy();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
